mem_bus_bridge: RTL and testbench

Slave side of the core's memory port. Accepts single-beat commands from the core's MEM_* interface, decodes the address into an on-chip block-RAM region or a memory-mapped I/O region, and performs byte-lane steering. It then returns right-aligned read data with a DataReady pulse. It sits directly downstream of the core and drives the core's MEM_Ready, MEM_DataIn and MEM_DataReady inputs.

---
 rtl/mem_bridge_pkg.sv | 27 ++
 rtl/mem_bus_bridge_if.sv | 23 ++
 rtl/mem_bridge_lane.sv | 45 ++++
 rtl/mem_bus_bridge.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the memory bus bridge
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BRAM_ACC  = 3'd1,
    ST_BRAM_WAIT = 3'd2,
    ST_IO_REQ    = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // MEM_ByteEnable encodings; 2'b11 is reserved and decodes as an error
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] IO_SPAN       = 32'h0001_0000;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Reserved size or an access not naturally aligned to its size
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) ||
           (size == SIZE_HALF && a[0]) ||
           (size == SIZE_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// rtl/mem_bus_bridge_if.sv - core-side MEM_* command/response bundle
// master: core (drives command, receives ready/read data)
// slave : bridge (receives command, drives ready/read data)
interface mem_bus_bridge_if;
  logic        MEM_Cmd;
  logic        MEM_We;
  logic [1:0]  MEM_ByteEnable;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_DataOut;
  logic        MEM_Ready;
  logic [31:0] MEM_DataIn;
  logic        MEM_DataReady;

  modport master (
    output MEM_Cmd, MEM_We, MEM_ByteEnable, MEM_Addr, MEM_DataOut,
    input  MEM_Ready, MEM_DataIn, MEM_DataReady
  );

  modport slave (
    input  MEM_Cmd, MEM_We, MEM_ByteEnable, MEM_Addr, MEM_DataOut,
    output MEM_Ready, MEM_DataIn, MEM_DataReady
  );
endinterface

// File: rtl/mem_bridge_lane.sv
// rtl/mem_bridge_lane.sv - byte-lane strobes, write replication, read align/mask
// size_i/addr_lo_i : access size code and byte offset within the word
// wdata_i/wdata_o  : right-aligned write data in, lane-replicated out
// rdata_raw_i      : raw 32-bit word from BRAM or MMIO
// rdata_o          : right-aligned, zero-filled read data
// strb_o           : byte strobes (zero for the reserved size)
module mem_bridge_lane
  import mem_bridge_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_raw_i >> {addr_lo_i, 3'b000};
    strb_o  = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'd0;
    case (size_i)
      SIZE_BYTE: begin
        strb_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'd0, shifted[7:0]};
      end
      SIZE_HALF: begin
        strb_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'd0, shifted[15:0]};
      end
      SIZE_WORD: begin
        strb_o  = 4'b1111;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - MEM_* slave decoding into BRAM and MMIO regions
// Clk/Reset : rising-edge clock, asynchronous active-low reset
// mem       : core command/response bundle (slave side)
// Bram_*    : single-cycle BRAM port, read data one cycle after Bram_En
// Io_*      : MMIO request held until Io_Ack
// BusError  : one-cycle pulse for unmapped/misaligned/reserved/timed-out access
// Optional  : MEM_BRIDGE_TIMEOUT_EN bounds Io_Req to IO_TIMEOUT cycles
module mem_bus_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [31:0] BRAM_BASE  = 32'h0000_0000,
  parameter int          BRAM_AW    = 12,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic               Clk,
  input  logic               Reset,
  mem_bus_bridge_if.slave    mem,
  output logic               Bram_En,
  output logic [3:0]         Bram_We,
  output logic [BRAM_AW-1:0] Bram_Addr,
  output logic [31:0]        Bram_WData,
  input  logic [31:0]        Bram_RData,
  output logic               Io_Req,
  output logic               Io_We,
  output logic [3:0]         Io_Strb,
  output logic [15:0]        Io_Addr,
  output logic [31:0]        Io_WData,
  input  logic               Io_Ack,
  input  logic [31:0]        Io_RData,
  output logic               BusError
);

  // Only the low address bits are ever needed after decode
  localparam int AQW = (BRAM_AW + 2 > 16) ? BRAM_AW + 2 : 16;

  state_e          state_q, state_d;
  logic            init_q;
  logic [AQW-1:0]  addr_q, addr_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic        in_bram, in_io;
  logic [3:0]  strb;
  logic [31:0] wrep, lane_rdata;

  assign in_bram = (mem.MEM_Addr[31:BRAM_AW+2] == BRAM_BASE[31:BRAM_AW+2]);
  assign in_io   = (((mem.MEM_Addr ^ IO_BASE) & ~(IO_SPAN - 32'd1)) == 32'd0);

  mem_bridge_lane u_lane (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_raw_i ((state_q == ST_IO_REQ) ? Io_RData : Bram_RData),
    .strb_o      (strb),
    .wdata_o     (wrep),
    .rdata_o     (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (init_q && mem.MEM_Cmd) begin
          addr_d  = mem.MEM_Addr[AQW-1:0];
          we_d    = mem.MEM_We;
          size_d  = mem.MEM_ByteEnable;
          wdata_d = mem.MEM_DataOut;
          err_d   = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (bad_access(mem.MEM_ByteEnable, mem.MEM_Addr[1:0])) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = ST_RESP;
          end else if (in_bram) begin
            state_d = ST_BRAM_ACC;
          end else if (in_io) begin
            state_d = ST_IO_REQ;
          end else begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = ST_RESP;
          end
        end
      end
      ST_BRAM_ACC:  state_d = we_q ? ST_IDLE : ST_BRAM_WAIT;
      ST_BRAM_WAIT: begin
        rdata_d = lane_rdata;
        state_d = ST_RESP;
      end
      ST_IO_REQ: begin
        // Ack wins over a simultaneous timeout
        if (Io_Ack) begin
          if (!we_q) rdata_d = lane_rdata;
          state_d = we_q ? ST_IDLE : ST_RESP;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = TIMEOUT_RDATA;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // init_q holds Ready low until the first edge after reset release
  assign mem.MEM_Ready     = init_q && (state_q == ST_IDLE);
  assign mem.MEM_DataIn    = rdata_q;
  assign mem.MEM_DataReady = (state_q == ST_RESP) && !we_q;
  assign BusError          = (state_q == ST_RESP) && err_q;

  assign Bram_En    = (state_q == ST_BRAM_ACC);
  assign Bram_We    = (Bram_En && we_q) ? strb : 4'b0000;
  assign Bram_Addr  = addr_q[BRAM_AW+1:2];
  assign Bram_WData = wrep;

  assign Io_Req   = (state_q == ST_IO_REQ);
  assign Io_We    = Io_Req && we_q;
  assign Io_Strb  = Io_Req ? strb : 4'b0000;
  assign Io_Addr  = addr_q[15:0];
  assign Io_WData = wrep;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - directed self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Bram_En;
  logic [3:0]  Bram_We;
  logic [11:0] Bram_Addr;
  logic [31:0] Bram_WData;
  logic [31:0] Bram_RData = 32'd0;
  logic        Io_Req;
  logic        Io_We;
  logic [3:0]  Io_Strb;
  logic [15:0] Io_Addr;
  logic [31:0] Io_WData;
  logic        Io_Ack = 1'b0;
  logic [31:0] Io_RData = 32'd0;
  logic        BusError;

  int checks = 0;
  int errors = 0;

  mem_bus_bridge_if bus ();

  mem_bus_bridge #(
    .BRAM_BASE  (32'h0000_0000),
    .BRAM_AW    (12),
    .IO_BASE    (32'h8000_0000),
    .IO_TIMEOUT (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .mem        (bus),
    .Bram_En    (Bram_En),
    .Bram_We    (Bram_We),
    .Bram_Addr  (Bram_Addr),
    .Bram_WData (Bram_WData),
    .Bram_RData (Bram_RData),
    .Io_Req     (Io_Req),
    .Io_We      (Io_We),
    .Io_Strb    (Io_Strb),
    .Io_Addr    (Io_Addr),
    .Io_WData   (Io_WData),
    .Io_Ack     (Io_Ack),
    .Io_RData   (Io_RData),
    .BusError   (BusError)
  );

  always #5 Clk = ~Clk;

  logic [31:0] bram [0:4095];
  always @(posedge Clk) begin
    if (Bram_En) begin
      for (int i = 0; i < 4; i++)
        if (Bram_We[i]) bram[Bram_Addr][8*i +: 8] <= Bram_WData[8*i +: 8];
      Bram_RData <= bram[Bram_Addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a command in an idle cycle; returns in cycle T+1
  task automatic issue(input logic we, input logic [1:0] be, input logic [31:0] a,
                       input logic [31:0] d);
    chk("ready_before_issue", {31'd0, bus.MEM_Ready}, 32'd1);
    bus.MEM_Cmd        = 1'b1;
    bus.MEM_We         = we;
    bus.MEM_ByteEnable = be;
    bus.MEM_Addr       = a;
    bus.MEM_DataOut    = d;
    step();
    bus.MEM_Cmd = 1'b0;
  endtask

  int n;
  int dr_seen;

  initial begin
    bus.MEM_Cmd        = 1'b0;
    bus.MEM_We         = 1'b0;
    bus.MEM_ByteEnable = 2'b00;
    bus.MEM_Addr       = 32'd0;
    bus.MEM_DataOut    = 32'd0;

    // Reset state
    step();
    step();
    chk("rst_ready",     {31'd0, bus.MEM_Ready}, 32'd0);
    chk("rst_datain",    bus.MEM_DataIn, 32'd0);
    chk("rst_dataready", {31'd0, bus.MEM_DataReady}, 32'd0);
    chk("rst_buserror",  {31'd0, BusError}, 32'd0);
    chk("rst_bram_en",   {31'd0, Bram_En}, 32'd0);
    chk("rst_bram_we",   {28'd0, Bram_We}, 32'd0);
    chk("rst_io_req",    {31'd0, Io_Req}, 32'd0);
    chk("rst_bram_addr", {20'd0, Bram_Addr}, 32'd0);
    chk("rst_bram_wdata", Bram_WData, 32'd0);
    chk("rst_io_addr",   {16'd0, Io_Addr}, 32'd0);
    chk("rst_io_strb",   {28'd0, Io_Strb}, 32'd0);
    Reset = 1'b1;
    #1;
    chk("ready_before_first_edge", {31'd0, bus.MEM_Ready}, 32'd0);
    step();
    chk("ready_after_first_edge", {31'd0, bus.MEM_Ready}, 32'd1);

    // Word write 0xA5A5_1234 to 0x10
    issue(1'b1, 2'b10, 32'h0000_0010, 32'hA5A5_1234);
    chk("ww_bram_en",    {31'd0, Bram_En}, 32'd1);
    chk("ww_bram_we",    {28'd0, Bram_We}, 32'hF);
    chk("ww_bram_addr",  {20'd0, Bram_Addr}, 32'd4);
    chk("ww_bram_wdata", Bram_WData, 32'hA5A5_1234);
    chk("ww_ready_t1",   {31'd0, bus.MEM_Ready}, 32'd0);
    step();
    chk("ww_ready_t2",   {31'd0, bus.MEM_Ready}, 32'd1);
    chk("ww_en_off_t2",  {31'd0, Bram_En}, 32'd0);

    // Word read back
    issue(1'b0, 2'b10, 32'h0000_0010, 32'd0);
    chk("wr_bram_en_t1", {31'd0, Bram_En}, 32'd1);
    chk("wr_bram_we_t1", {28'd0, Bram_We}, 32'd0);
    step();
    chk("wr_dr_t2",      {31'd0, bus.MEM_DataReady}, 32'd0);
    step();
    chk("wr_dr_t3",      {31'd0, bus.MEM_DataReady}, 32'd1);
    chk("wr_data_t3",    bus.MEM_DataIn, 32'hA5A5_1234);
    chk("wr_ready_t3",   {31'd0, bus.MEM_Ready}, 32'd0);
    step();
    chk("wr_dr_t4",      {31'd0, bus.MEM_DataReady}, 32'd0);

    // Byte write 0xEF to 0x13
    issue(1'b1, 2'b00, 32'h0000_0013, 32'h0000_00EF);
    chk("bw_bram_we",    {28'd0, Bram_We}, 32'h8);
    chk("bw_bram_wdata", Bram_WData, 32'hEFEF_EFEF);
    chk("bw_bram_addr",  {20'd0, Bram_Addr}, 32'd4);
    step();

    // Byte read 0x13 -> 0xEF
    issue(1'b0, 2'b00, 32'h0000_0013, 32'd0);
    step();
    step();
    chk("br_dr",   {31'd0, bus.MEM_DataReady}, 32'd1);
    chk("br_data", bus.MEM_DataIn, 32'h0000_00EF);
    step();

    // Half read 0x12 -> upper half of 0xEFA5_1234
    issue(1'b0, 2'b01, 32'h0000_0012, 32'd0);
    step();
    step();
    chk("hr_data", bus.MEM_DataIn, 32'h0000_EFA5);
    step();

    // Misaligned half read at 0x11
    issue(1'b0, 2'b01, 32'h0000_0011, 32'd0);
    chk("mis_buserror", {31'd0, BusError}, 32'd1);
    chk("mis_dr",       {31'd0, bus.MEM_DataReady}, 32'd1);
    chk("mis_data",     bus.MEM_DataIn, 32'd0);
    chk("mis_bram_en",  {31'd0, Bram_En}, 32'd0);
    step();
    chk("mis_ready_t2", {31'd0, bus.MEM_Ready}, 32'd1);
    chk("mis_be_off",   {31'd0, BusError}, 32'd0);

    // Reserved-size write: error, no strobes, no DataReady
    issue(1'b1, 2'b11, 32'h0000_0020, 32'h1111_1111);
    chk("rsv_buserror", {31'd0, BusError}, 32'd1);
    chk("rsv_dr",       {31'd0, bus.MEM_DataReady}, 32'd0);
    chk("rsv_bram_en",  {31'd0, Bram_En}, 32'd0);
    chk("rsv_io_req",   {31'd0, Io_Req}, 32'd0);
    step();

    // First byte past BRAM region is unmapped
    issue(1'b0, 2'b10, 32'h0000_4000, 32'd0);
    chk("bram_end_err", {31'd0, BusError}, 32'd1);
    chk("bram_end_en",  {31'd0, Bram_En}, 32'd0);
    step();

    // First byte past MMIO region is unmapped
    issue(1'b0, 2'b10, 32'h8001_0000, 32'd0);
    chk("io_end_err", {31'd0, BusError}, 32'd1);
    chk("io_end_req", {31'd0, Io_Req}, 32'd0);
    step();

    // MMIO read at 0x8000_0004, Ack held off 5 cycles
    issue(1'b0, 2'b10, 32'h8000_0004, 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (Io_Req === 1'b1 && Io_Addr === 16'd4 && Io_Strb === 4'hF && Io_We === 1'b0 &&
          bus.MEM_DataReady === 1'b0)
        n++;
      step();
    end
    Io_Ack   = 1'b1;
    Io_RData = 32'h1234_5678;
    if (Io_Req === 1'b1) n++;
    chk("io_req_stable_cycles", n, 32'd6);
    step();
    Io_Ack   = 1'b0;
    Io_RData = 32'hDEAD_BEEF;
    chk("io_req_dropped", {31'd0, Io_Req}, 32'd0);
    chk("io_dr",          {31'd0, bus.MEM_DataReady}, 32'd1);
    chk("io_data",        bus.MEM_DataIn, 32'h1234_5678);
    step();
    chk("io_ready",       {31'd0, bus.MEM_Ready}, 32'd1);

    // Stray Ack while idle is ignored
    Io_Ack = 1'b1;
    step();
    Io_Ack = 1'b0;
    chk("stray_ack_dr",    {31'd0, bus.MEM_DataReady}, 32'd0);
    chk("stray_ack_ready", {31'd0, bus.MEM_Ready}, 32'd1);

    // MMIO byte write at 0x8000_0102, immediate Ack
    issue(1'b1, 2'b00, 32'h8000_0102, 32'h0000_0055);
    chk("iow_strb",  {28'd0, Io_Strb}, 32'h4);
    chk("iow_wdata", Io_WData, 32'h5555_5555);
    chk("iow_we",    {31'd0, Io_We}, 32'd1);
    chk("iow_addr",  {16'd0, Io_Addr}, 32'h0102);
    Io_Ack = 1'b1;
    step();
    Io_Ack = 1'b0;
    chk("iow_ready", {31'd0, bus.MEM_Ready}, 32'd1);
    chk("iow_dr",    {31'd0, bus.MEM_DataReady}, 32'd0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Timeout: Ack never arrives
    issue(1'b0, 2'b10, 32'h8000_0008, 32'd0);
    n = 0;
    while (Io_Req === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 32'd8);
    chk("to_buserror",   {31'd0, BusError}, 32'd1);
    chk("to_dr",         {31'd0, bus.MEM_DataReady}, 32'd1);
    chk("to_data",       bus.MEM_DataIn, 32'hFFFF_FFFF);
    step();
`endif

    // Reset in the middle of an MMIO read
    issue(1'b0, 2'b10, 32'h8000_0000, 32'd0);
    step();
    chk("mid_req_before", {31'd0, Io_Req}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid_req_after",   {31'd0, Io_Req}, 32'd0);
    chk("mid_ready_after", {31'd0, bus.MEM_Ready}, 32'd0);
    step();
    Io_Ack   = 1'b1;
    Io_RData = 32'hCAFE_F00D;
    step();
    Reset  = 1'b1;
    Io_Ack = 1'b0;
    dr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.MEM_DataReady === 1'b1 || Io_Req === 1'b1 || Bram_En === 1'b1) dr_seen++;
    end
    chk("mid_no_response", dr_seen, 32'd0);
    chk("mid_ready_back",  {31'd0, bus.MEM_Ready}, 32'd1);
    chk("mid_datain",      bus.MEM_DataIn, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
